// File: rtl/cu_read_command_arbiter.sv
// Round-robin arbiter sharing the CU read-command path between requesters,
// with a response-driven read-credit budget and a drain/quiesce sequence.
package cu_read_command_arbiter_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] payload;
   } CommandBufferLine;

   typedef struct packed {
      logic alfull;
   } BufferStatus;

   typedef struct packed {
      logic valid;
   } ResponseBufferLine;
endpackage

module cu_read_command_arbiter
   import cu_read_command_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 4,
   parameter int READ_CREDITS   = 16,
   parameter int CREDIT_WIDTH   = $clog2(READ_CREDITS + 1)
) (
   input  logic                                   clock,
   input  logic                                   rstn_in,
   input  logic                                   enabled_in,
   input  logic                                   drain_in,
   input  CommandBufferLine [NUM_REQUESTERS-1:0]  command_in,
   output logic [NUM_REQUESTERS-1:0]              ready_out,
   input  BufferStatus                            read_buffer_status,
   input  ResponseBufferLine                      read_response_in,
   output CommandBufferLine                       read_command_out,
   output logic [CREDIT_WIDTH-1:0]                outstanding_out,
   output logic                                   drained_out,
   output logic                                   credit_error_out
);
   localparam int PTR_W = $clog2(NUM_REQUESTERS);
   localparam logic [CREDIT_WIDTH-1:0] MAX_CRED = CREDIT_WIDTH'(READ_CREDITS);

   typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

   state_t                  state_q;
   logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
   logic [CREDIT_WIDTH-1:0] outstanding_q;
   CommandBufferLine        cmd_q, cmd_d;
   logic                    drained_q, err_q, err_d;
   logic [PTR_W-1:0]        grant_idx;
   logic                    grant_found, grant, resp_ok, resp_err, drain_done;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         if (!grant_found && command_in[(int'(rr_ptr_q) + k) % NUM_REQUESTERS].valid) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQUESTERS);
         end
      end
   end

   // drain_in blocks grants combinationally so the first drain cycle never issues.
   assign grant = rstn_in && (state_q == RUN) && !drain_in && enabled_in &&
                  !read_buffer_status.alfull && (credits_q != '0) && grant_found;

   always_comb begin
      ready_out = '0;
      if (grant) ready_out[grant_idx] = 1'b1;
   end

   assign resp_ok    = read_response_in.valid && (credits_q != MAX_CRED);
   assign resp_err   = read_response_in.valid && (credits_q == MAX_CRED);
   assign drain_done = (credits_q == MAX_CRED) && !cmd_q.valid;

   always_comb begin
      credits_d = credits_q;
      if (grant && !resp_ok)      credits_d = credits_q - 1'b1;
      else if (!grant && resp_ok) credits_d = credits_q + 1'b1;
      err_d = err_q | resp_err;
      rr_ptr_d = rr_ptr_q;
      if (grant) rr_ptr_d = (int'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : grant_idx + 1'b1;
      cmd_d       = cmd_q;
      cmd_d.valid = 1'b0;
      if (grant) cmd_d = command_in[grant_idx];
   end

   always_ff @(posedge clock or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q       <= RUN;
         drained_q     <= 1'b0;
         rr_ptr_q      <= '0;
         credits_q     <= MAX_CRED;
         outstanding_q <= '0;
         cmd_q         <= '0;
         err_q         <= 1'b0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         credits_q     <= credits_d;
         outstanding_q <= MAX_CRED - credits_d;
         cmd_q         <= cmd_d;
         err_q         <= err_d;
         case (state_q)
            RUN: begin
               if (drain_in) state_q <= DRAIN;
               drained_q <= 1'b0;
            end
            DRAIN: begin
               if (!drain_in) begin
                  state_q   <= RUN;
                  drained_q <= 1'b0;
               end else if (drain_done) begin
                  state_q   <= DRAINED;
                  drained_q <= 1'b1;
               end
            end
            DRAINED: begin
               if (!drain_in) begin
                  state_q   <= RUN;
                  drained_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= RUN;
               drained_q <= 1'b0;
            end
         endcase
      end
   end

   assign read_command_out = cmd_q;
   assign outstanding_out  = outstanding_q;
   assign drained_out      = drained_q;
   assign credit_error_out = err_q;
endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run, all against
// a cycle-level reference model of the arbitration and credit rules.
module tb_cu_read_command_arbiter;
   import cu_read_command_arbiter_pkg::*;
   localparam int N  = 4;
   localparam int RC = 4;
   localparam int CW = $clog2(RC + 1);

   logic clock = 1'b0;
   logic rstn_in, enabled_in, drain_in;
   CommandBufferLine [N-1:0] command_in;
   logic [N-1:0] ready_out;
   BufferStatus read_buffer_status;
   ResponseBufferLine read_response_in;
   CommandBufferLine read_command_out;
   logic [CW-1:0] outstanding_out;
   logic drained_out, credit_error_out;

   int tests = 0, fails = 0;

   // Reference model state: credits, next-in-line pointer, mode 0=run 1=drain 2=drained.
   int m_cred, m_ptr, m_mode;
   logic m_cv, m_err;
   logic [31:0] m_cp;

   cu_read_command_arbiter #(.NUM_REQUESTERS(N), .READ_CREDITS(RC)) dut (
      .clock(clock), .rstn_in(rstn_in), .enabled_in(enabled_in), .drain_in(drain_in),
      .command_in(command_in), .ready_out(ready_out), .read_buffer_status(read_buffer_status),
      .read_response_in(read_response_in), .read_command_out(read_command_out),
      .outstanding_out(outstanding_out), .drained_out(drained_out),
      .credit_error_out(credit_error_out));

   always #5 clock = ~clock;

   function automatic int pick();
      if (!rstn_in || m_mode != 0 || drain_in || !enabled_in ||
          read_buffer_status.alfull || m_cred == 0) return -1;
      for (int k = 0; k < N; k++)
         if (command_in[(m_ptr + k) % N].valid) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      int g;
      r = '0;
      g = pick();
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   function automatic CommandBufferLine exp_cmd();
      CommandBufferLine c;
      c.valid   = m_cv;
      c.payload = m_cp;
      return c;
   endfunction

   task automatic model_reset();
      m_cred = RC; m_ptr = 0; m_mode = 0; m_cv = 1'b0; m_cp = '0; m_err = 1'b0;
   endtask

   // Advance one clock and step the model with the inputs held across the edge.
   task automatic tick();
      int g;
      logic done, rv;
      g    = pick();
      done = (m_cred == RC) && !m_cv;
      rv   = read_response_in.valid;
      @(posedge clock);
      case (m_mode)
         0: if (drain_in) m_mode = 1;
         1: if (!drain_in) m_mode = 0; else if (done) m_mode = 2;
         default: if (!drain_in) m_mode = 0;
      endcase
      if (rv && m_cred == RC) m_err = 1'b1;
      m_cred = m_cred - ((g >= 0) ? 1 : 0) + ((rv && m_cred != RC) ? 1 : 0);
      m_cv = (g >= 0);
      if (g >= 0) begin
         m_cp  = command_in[g].payload;
         m_ptr = (g + 1) % N;
      end
      #1;
   endtask

   task automatic set_valid(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         command_in[i].valid   = v[i];
         command_in[i].payload = $urandom;
      end
   endtask

   task automatic apply_reset();
      rstn_in = 1'b0; enabled_in = 1'b0; drain_in = 1'b0;
      read_buffer_status = '0; read_response_in = '0;
      set_valid('0);
      model_reset();
      repeat (2) @(posedge clock);
      #1 rstn_in = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      #2;
      tests++;
      if (ready_out !== '0 || read_command_out !== '0 || outstanding_out !== '0 ||
          drained_out !== 1'b0 || credit_error_out !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: ready=%b cmd=%h outst=%0d drained=%b err=%b, want all 0",
                  ready_out, read_command_out, outstanding_out, drained_out, credit_error_out);
      end
   endtask

   task automatic test_fairness();
      apply_reset();
      enabled_in = 1'b1;
      for (int k = 0; k < 8; k++) begin
         set_valid('1);
         read_response_in.valid = (m_cred < RC);
         #2;
         tests++;
         if (ready_out !== N'(1 << (k % N)) || ready_out !== exp_ready()) begin
            fails++;
            $display("FAIL fairness_grant[%0d]: ready=%b want %b", k, ready_out, N'(1 << (k % N)));
         end
         tick();
         tests++;
         if (read_command_out !== exp_cmd() || read_command_out.valid !== 1'b1) begin
            fails++;
            $display("FAIL fairness_cmd[%0d]: got %h want %h", k, read_command_out, exp_cmd());
         end
      end
   endtask

   task automatic test_sparse();
      int seq[4] = '{3, 1, 3, 1};
      set_valid(4'b0010);
      read_response_in.valid = (m_cred < RC);
      #2 tick();
      for (int k = 0; k < 4; k++) begin
         set_valid(4'b1010);
         read_response_in.valid = (m_cred < RC);
         #2;
         tests++;
         if (ready_out !== N'(1 << seq[k]) || (ready_out & 4'b0101) !== '0) begin
            fails++;
            $display("FAIL sparse_grant[%0d]: ready=%b want %b", k, ready_out, N'(1 << seq[k]));
         end
         tick();
      end
      read_response_in.valid = 1'b0;
   endtask

   task automatic test_credit_limit();
      apply_reset();
      enabled_in = 1'b1;
      for (int k = 0; k < RC; k++) begin
         set_valid('1);
         #2;
         tests++;
         if (ready_out === '0 || ready_out !== exp_ready()) begin
            fails++;
            $display("FAIL credit_grant[%0d]: ready=%b want %b", k, ready_out, exp_ready());
         end
         tick();
      end
      set_valid('1);
      #2;
      tests++;
      if (ready_out !== '0 || outstanding_out !== CW'(RC)) begin
         fails++;
         $display("FAIL credit_exhausted: ready=%b outst=%0d want 0 and %0d", ready_out, outstanding_out, RC);
      end
      read_response_in.valid = 1'b1;
      tick();
      read_response_in.valid = 1'b0;
      #2;
      tests++;
      if (ready_out !== exp_ready() || ready_out === '0) begin
         fails++;
         $display("FAIL credit_one_more: ready=%b want %b", ready_out, exp_ready());
      end
      tick();
      #2;
      tests++;
      if (ready_out !== '0) begin
         fails++;
         $display("FAIL credit_only_one: ready=%b want 0", ready_out);
      end
      read_response_in.valid = 1'b1;
      tick();
      #2;
      tick();
      read_response_in.valid = 1'b0;
      tests++;
      if (outstanding_out !== CW'(RC - 1) || read_command_out.valid !== 1'b1) begin
         fails++;
         $display("FAIL credit_grant_and_resp: outst=%0d cmdv=%b want %0d and 1",
                  outstanding_out, read_command_out.valid, RC - 1);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      enabled_in = 1'b1;
      for (int k = 0; k < 2; k++) begin
         set_valid('1);
         read_response_in.valid = (m_cred < RC);
         #2 tick();
      end
      read_buffer_status.alfull = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_valid('1);
         read_response_in.valid = (m_cred < RC);
         #2;
         tests++;
         if (ready_out !== '0) begin
            fails++;
            $display("FAIL alfull_stall[%0d]: ready=%b want 0", k, ready_out);
         end
         tick();
      end
      read_buffer_status.alfull = 1'b0;
      read_response_in.valid = 1'b0;
      #2;
      tests++;
      if (ready_out !== 4'b0100) begin
         fails++;
         $display("FAIL alfull_resume: ready=%b want 0100", ready_out);
      end
      tick();
   endtask

   task automatic test_drain();
      apply_reset();
      enabled_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_valid('1);
         #2 tick();
      end
      drain_in = 1'b1;
      #2;
      tests++;
      if (ready_out !== '0) begin
         fails++;
         $display("FAIL drain_first_cycle: ready=%b want 0", ready_out);
      end
      tick();
      tick();
      for (int r = 0; r < 3; r++) begin
         read_response_in.valid = 1'b1;
         #2;
         tests++;
         if (ready_out !== '0) begin
            fails++;
            $display("FAIL drain_no_grant[%0d]: ready=%b want 0", r, ready_out);
         end
         tick();
         tests++;
         if (drained_out !== 1'b0) begin
            fails++;
            $display("FAIL drain_early[%0d]: drained=%b want 0", r, drained_out);
         end
      end
      read_response_in.valid = 1'b0;
      tick();
      tests++;
      if (drained_out !== 1'b1 || outstanding_out !== '0) begin
         fails++;
         $display("FAIL drained_rise: drained=%b outst=%0d want 1 and 0", drained_out, outstanding_out);
      end
      drain_in = 1'b0;
      tick();
      #2;
      tests++;
      if (ready_out !== 4'b1000 || drained_out !== 1'b0) begin
         fails++;
         $display("FAIL drain_resume: ready=%b drained=%b want 1000 and 0", ready_out, drained_out);
      end
      tick();
   endtask

   task automatic test_error_and_reset();
      apply_reset();
      read_response_in.valid = 1'b1;
      tick();
      read_response_in.valid = 1'b0;
      tests++;
      if (credit_error_out !== 1'b1) begin
         fails++;
         $display("FAIL credit_error_set: err=%b want 1", credit_error_out);
      end
      repeat (3) tick();
      tests++;
      if (credit_error_out !== 1'b1) begin
         fails++;
         $display("FAIL credit_error_sticky: err=%b want 1", credit_error_out);
      end
      enabled_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_valid('1);
         #2 tick();
      end
      #3 rstn_in = 1'b0;
      model_reset();
      #1;
      tests++;
      if (ready_out !== '0 || read_command_out !== '0 || outstanding_out !== '0 ||
          drained_out !== 1'b0 || credit_error_out !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: ready=%b cmd=%h outst=%0d drained=%b err=%b, want all 0",
                  ready_out, read_command_out, outstanding_out, drained_out, credit_error_out);
      end
      @(posedge clock);
      #1 rstn_in = 1'b1;
      for (int k = 0; k < RC; k++) begin
         set_valid('1);
         #2;
         tests++;
         if (ready_out !== N'(1 << k)) begin
            fails++;
            $display("FAIL reset_credits[%0d]: ready=%b want %b", k, ready_out, N'(1 << k));
         end
         tick();
      end
      set_valid('0);
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         set_valid(N'($urandom));
         enabled_in = ($urandom_range(0, 9) != 0);
         read_buffer_status.alfull = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 19) == 0) drain_in = ~drain_in;
         read_response_in.valid = (m_cred < RC) ? ($urandom_range(0, 2) == 0)
                                                : ($urandom_range(0, 49) == 0);
         #2;
         tests++;
         if (ready_out !== exp_ready()) begin
            fails++;
            $display("FAIL random_ready[%0d]: got %b want %b", c, ready_out, exp_ready());
         end
         tick();
         tests++;
         if (read_command_out !== exp_cmd() || outstanding_out !== CW'(RC - m_cred) ||
             drained_out !== (m_mode == 2) || credit_error_out !== m_err) begin
            fails++;
            $display("FAIL random_state[%0d]: cmd=%h/%h outst=%0d/%0d drained=%b/%b err=%b/%b",
                     c, read_command_out, exp_cmd(), outstanding_out, RC - m_cred,
                     drained_out, (m_mode == 2), credit_error_out, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_sparse();
      test_credit_limit();
      test_backpressure();
      test_drain();
      test_error_and_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
